// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - control and display signal bundle for seg7_scan
interface seg7_scan_if;
  logic        en;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        pend;
  logic        wr_ack;
  logic        frame;
  logic [3:0]  dig_data;
  logic [3:0]  an;

  modport master (
    output en, wr_en, wr_data,
    input  pend, wr_ack, frame, dig_data, an
  );

  modport slave (
    input  en, wr_en, wr_data,
    output pend, wr_ack, frame, dig_data, an
  );
endinterface

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - four-digit multiplexed 7-segment scanner with frame-synchronous updates
module seg7_scan #(
  parameter int DIV  = 1000,
  parameter int DEAD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  seg7_scan_if.slave  bus
);

  typedef enum logic [1:0] {ST_OFF, ST_DEAD, ST_SHOW} state_t;

  localparam logic [15:0] DEAD_LAST = 16'(DEAD - 1);
  localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [15:0] r_cnt;
  logic [15:0] r_disp;
  logic [15:0] r_pending;
  logic        r_pend;
  logic        r_wr_ack;
  logic        r_frame;
  logic [3:0]  r_an;
  logic [3:0]  r_dig;

  state_t      w_state_nxt;
  logic [1:0]  w_idx_nxt;
  logic [15:0] w_cnt_nxt;
  logic        w_boundary;
  logic [15:0] w_disp_nxt;
  logic [15:0] w_pending_nxt;
  logic        w_pend_nxt;
  logic        w_ack_nxt;
  logic [3:0]  w_an_nxt;
  logic [3:0]  w_dig_nxt;

  // Next scan position; a boundary is any entry into DEAD at digit 0
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_boundary  = 1'b0;
    case (r_state)
      ST_OFF: begin
        w_idx_nxt = 2'd0;
        w_cnt_nxt = 16'd0;
        if (bus.en) begin
          w_state_nxt = ST_DEAD;
          w_boundary  = 1'b1;
        end
      end
      ST_DEAD: begin
        if (!bus.en) begin
          w_state_nxt = ST_OFF;
          w_idx_nxt   = 2'd0;
          w_cnt_nxt   = 16'd0;
        end else if (r_cnt == DEAD_LAST) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = 16'd0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      ST_SHOW: begin
        if (!bus.en) begin
          w_state_nxt = ST_OFF;
          w_idx_nxt   = 2'd0;
          w_cnt_nxt   = 16'd0;
        end else if (r_cnt == DIV_LAST) begin
          w_state_nxt = ST_DEAD;
          w_cnt_nxt   = 16'd0;
          w_idx_nxt   = r_idx + 2'd1;
          w_boundary  = (r_idx == 2'd3);
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
        w_idx_nxt   = 2'd0;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  // Display/pending update: apply at the boundary first, then a same-edge write lands in pending
  always_comb begin
    w_disp_nxt    = r_disp;
    w_pending_nxt = r_pending;
    w_pend_nxt    = r_pend;
    w_ack_nxt     = 1'b0;
    if (w_boundary && r_pend) begin
      w_disp_nxt = r_pending;
      w_pend_nxt = 1'b0;
      w_ack_nxt  = 1'b1;
    end
    if (bus.wr_en) begin
      if (r_state == ST_OFF && !w_boundary) begin
        // Blank display: no frame to tear, so the value goes straight to disp
        w_disp_nxt = bus.wr_data;
        w_pend_nxt = 1'b0;
        w_ack_nxt  = 1'b1;
      end else begin
        w_pending_nxt = bus.wr_data;
        w_pend_nxt    = 1'b1;
      end
    end
  end

  // Output values for the cycle after the edge, derived from the next state
  always_comb begin
    w_an_nxt = 4'b1111;
    if (w_state_nxt == ST_SHOW) begin
      case (w_idx_nxt)
        2'd0:    w_an_nxt = 4'b1110;
        2'd1:    w_an_nxt = 4'b1101;
        2'd2:    w_an_nxt = 4'b1011;
        default: w_an_nxt = 4'b0111;
      endcase
    end
    case (w_idx_nxt)
      2'd0:    w_dig_nxt = w_disp_nxt[3:0];
      2'd1:    w_dig_nxt = w_disp_nxt[7:4];
      2'd2:    w_dig_nxt = w_disp_nxt[11:8];
      default: w_dig_nxt = w_disp_nxt[15:12];
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_OFF;
      r_idx     <= 2'd0;
      r_cnt     <= 16'd0;
      r_disp    <= 16'd0;
      r_pending <= 16'd0;
      r_pend    <= 1'b0;
      r_wr_ack  <= 1'b0;
      r_frame   <= 1'b0;
      r_an      <= 4'b1111;
      r_dig     <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_disp    <= w_disp_nxt;
      r_pending <= w_pending_nxt;
      r_pend    <= w_pend_nxt;
      r_wr_ack  <= w_ack_nxt;
      r_frame   <= w_boundary;
      r_an      <= w_an_nxt;
      r_dig     <= w_dig_nxt;
    end
  end

  assign bus.pend     = r_pend;
  assign bus.wr_ack   = r_wr_ack;
  assign bus.frame    = r_frame;
  assign bus.dig_data = r_dig;
  assign bus.an       = r_an;

endmodule
